// File: rtl/adder_tree_operand_loader_pkg.sv
// Shared adder-tree definitions: default operand geometry and the loader
// FSM state encoding.
package adder_tree_operand_loader_pkg;

  localparam int DEF_ADDER_WIDTH  = 16;
  localparam int DEF_NUM_OPERANDS = 8;

  // FILL: accepting words into the fill buffer.
  // HOLD: a closed frame is parked until the output register frees up.
  typedef enum logic {
    LD_FILL = 1'b0,
    LD_HOLD = 1'b1
  } ld_state_e;

endpackage

// File: rtl/adder_tree_operand_loader.sv
// adder_tree_operand_loader
//   Gathers a stream of operand words into one parallel frame for the
//   adder-tree input register. Frames close after NUM_OPERANDS words or on an
//   in_last word, whichever comes first. Unwritten slots of a short frame read
//   back as zero. One frame can wait in the fill buffer while the previous one
//   sits in the output register.
// Ports
//   clk, rst_n         clock, async active-low reset
//   in_data/valid/last upstream word stream; in_ready is the accept handshake
//   out_isum           parallel frame, slot k at [k*ADDER_WIDTH +: ADDER_WIDTH]
//   out_count          number of real words in the frame (1..NUM_OPERANDS)
//   out_valid/ready    frame handshake with the consumer
module adder_tree_operand_loader
  import adder_tree_operand_loader_pkg::*;
#(
  parameter int ADDER_WIDTH  = DEF_ADDER_WIDTH,
  parameter int NUM_OPERANDS = DEF_NUM_OPERANDS,
  localparam int CW          = $clog2(NUM_OPERANDS) + 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [ADDER_WIDTH-1:0]            in_data,
  input  logic                              in_valid,
  input  logic                              in_last,
  output logic                              in_ready,
  output logic [NUM_OPERANDS*ADDER_WIDTH-1:0] out_isum,
  output logic [CW-1:0]                     out_count,
  output logic                              out_valid,
  input  logic                              out_ready
);

  typedef logic [NUM_OPERANDS-1:0][ADDER_WIDTH-1:0] frame_t;

  ld_state_e state_q, state_d;
  frame_t    fill_q, fill_d;
  logic [CW-1:0] idx_q, idx_d;
  frame_t    osum_q, osum_d;
  logic [CW-1:0] ocnt_q, ocnt_d;
  logic      ovld_q, ovld_d;

  frame_t    frame;
  logic      accept, close, slot_free;

  assign in_ready  = (state_q == LD_FILL);
  assign out_isum  = osum_q;
  assign out_count = ocnt_q;
  assign out_valid = ovld_q;

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    idx_d     = idx_q;
    osum_d    = osum_q;
    ocnt_d    = ocnt_q;
    ovld_d    = ovld_q;
    slot_free = !ovld_q || out_ready;
    accept    = in_valid && (state_q == LD_FILL);
    // The buffer is zero beyond idx_q, so merging the incoming word gives the
    // complete frame including the word accepted at this edge.
    frame     = fill_q;
    for (int k = 0; k < NUM_OPERANDS; k++)
      if (idx_q == CW'(k)) frame[k] = in_data;
    // The count wins on the last slot; in_last there changes nothing.
    close     = accept && ((idx_q == CW'(NUM_OPERANDS - 1)) || in_last);

    // Consumer took the frame; a load below may re-assert valid.
    if (ovld_q && out_ready) ovld_d = 1'b0;

    case (state_q)
      LD_FILL: begin
        if (close && slot_free) begin
          osum_d = frame;
          ocnt_d = idx_q + CW'(1);
          ovld_d = 1'b1;
          fill_d = '0;
          idx_d  = '0;
        end else if (accept) begin
          // A closed frame that can't move keeps idx_q = word count for HOLD.
          fill_d = frame;
          idx_d  = idx_q + CW'(1);
          if (close) state_d = LD_HOLD;
        end
      end
      LD_HOLD: begin
        if (slot_free) begin
          osum_d  = fill_q;
          ocnt_d  = idx_q;
          ovld_d  = 1'b1;
          fill_d  = '0;
          idx_d   = '0;
          state_d = LD_FILL;
        end
      end
      default: state_d = LD_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LD_FILL;
      fill_q  <= '0;
      idx_q   <= '0;
      osum_q  <= '0;
      ocnt_q  <= '0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      idx_q   <= idx_d;
      osum_q  <= osum_d;
      ocnt_q  <= ocnt_d;
      ovld_q  <= ovld_d;
    end
  end

endmodule

// File: tb/tb_adder_tree_operand_loader.sv
module tb_adder_tree_operand_loader;
  localparam int W  = 16;
  localparam int N  = 8;
  localparam int CW = $clog2(N) + 1;
  localparam int FW = N * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [FW-1:0] out_isum;
  logic [CW-1:0] out_count;
  logic          out_valid;
  logic          out_ready = 1'b1;

  adder_tree_operand_loader #(.ADDER_WIDTH(W), .NUM_OPERANDS(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_isum(out_isum),
    .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready));

  always #5 clk = ~clk;

  typedef struct { logic [FW-1:0] isum; int cnt; } frm_t;

  int n_vec = 0, n_err = 0;
  logic [W-1:0] part[$];   // words of the frame being gathered
  frm_t exp_q[$];          // closed, not yet consumed frames (oldest first)
  frm_t got_q[$];          // frames the consumer actually took
  bit   mon_en = 1'b0;
  int   n_rdy0 = 0, n_vld = 0;

  task automatic chk(input string nm, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [W-1:0] slot(input logic [FW-1:0] s, input int k);
    return s[k*W +: W];
  endfunction

  // Abstract model: at most two frames can be outstanding (output register +
  // parked frame), so valid/ready follow directly from the queue depth.
  always @(negedge clk) begin
    if (!rst_n) begin
      part.delete();
      exp_q.delete();
      chk("rst_out_valid", FW'(out_valid), '0);
      chk("rst_out_isum", out_isum, '0);
      chk("rst_out_count", FW'(out_count), '0);
    end else begin
      bit rdy, mv;
      rdy = exp_q.size() < 2;
      mv  = exp_q.size() > 0;
      chk("out_valid", FW'(out_valid), FW'(mv));
      chk("in_ready", FW'(in_ready), FW'(rdy));
      if (mv) begin
        chk("out_isum", out_isum, exp_q[0].isum);
        chk("out_count", FW'(out_count), FW'(exp_q[0].cnt));
      end
      if (out_valid && out_ready) got_q.push_back('{out_isum, int'(out_count)});
      if (mon_en) begin
        if (!in_ready) n_rdy0++;
        if (out_valid) n_vld++;
      end
      if (mv && out_ready) void'(exp_q.pop_front());
      if (in_valid && rdy) begin
        part.push_back(in_data);
        if (part.size() == N || in_last) begin
          frm_t f;
          f.isum = '0;
          foreach (part[k]) f.isum[k*W +: W] = part[k];
          f.cnt = part.size();
          exp_q.push_back(f);
          part.delete();
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input bit l);
    bit acc;
    int guard = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 60);
    if (!acc) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: word %h not accepted, expected accept within 60 cycles", d);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("ready_after_reset", FW'(in_ready), FW'(1));

    // Full frame, consumer ready
    got_q.delete();
    for (int i = 1; i <= 8; i++) send(W'(i), 1'b0);
    in_valid = 1'b0;
    chk("s1_valid_next", FW'(out_valid), FW'(1));
    idle(3);
    chk("s1_nframes", FW'(got_q.size()), FW'(1));
    if (got_q.size() >= 1) begin
      chk("s1_slot0", FW'(slot(got_q[0].isum, 0)), FW'(16'h0001));
      chk("s1_slot7", FW'(slot(got_q[0].isum, 7)), FW'(16'h0008));
      chk("s1_count", FW'(got_q[0].cnt), FW'(8));
    end

    // Short frame via in_last
    got_q.delete();
    send(16'hAAAA, 1'b0); send(16'h5555, 1'b0); send(16'hFFFF, 1'b1);
    idle(3);
    chk("s2_nframes", FW'(got_q.size()), FW'(1));
    if (got_q.size() >= 1) begin
      chk("s2_count", FW'(got_q[0].cnt), FW'(3));
      chk("s2_low", got_q[0].isum & FW'(48'hFFFF_FFFF_FFFF), FW'(48'hFFFF_5555_AAAA));
      chk("s2_zero_hi", got_q[0].isum >> 48, '0);
    end

    // Backpressure: two frames stack up, then drain in order
    got_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(W'(16'h0100 + i), 1'b0);
    in_valid = 1'b0;
    chk("s3_hold_ready", FW'(in_ready), FW'(0));
    idle(4);
    chk("s3_still_hold", FW'(in_ready), FW'(0));
    out_ready = 1'b1;
    idle(4);
    chk("s3_nframes", FW'(got_q.size()), FW'(2));
    if (got_q.size() >= 2) begin
      chk("s3_f1_slot0", FW'(slot(got_q[0].isum, 0)), FW'(16'h0100));
      chk("s3_f1_slot7", FW'(slot(got_q[0].isum, 7)), FW'(16'h0107));
      chk("s3_f2_slot0", FW'(slot(got_q[1].isum, 0)), FW'(16'h0108));
      chk("s3_f2_slot7", FW'(slot(got_q[1].isum, 7)), FW'(16'h010F));
    end

    // in_last on the last slot changes nothing
    got_q.delete();
    for (int i = 0; i < 8; i++) send(W'(16'h0200 + i), i == 7);
    idle(3);
    chk("s3b_count", (got_q.size() >= 1) ? FW'(got_q[0].cnt) : '0, FW'(8));

    // Streaming: 32 words back-to-back
    got_q.delete();
    n_rdy0 = 0; n_vld = 0; mon_en = 1'b1;
    for (int i = 0; i < 32; i++) send(W'(16'h3000 + i), 1'b0);
    idle(3);
    mon_en = 1'b0;
    chk("s4_nframes", FW'(got_q.size()), FW'(4));
    chk("s4_ready_low_cycles", FW'(n_rdy0), FW'(0));
    chk("s4_valid_cycles", FW'(n_vld), FW'(4));
    if (got_q.size() >= 4)
      chk("s4_f4_slot7", FW'(slot(got_q[3].isum, 7)), FW'(16'h301F));

    // Reset mid-frame discards partial words
    got_q.delete();
    for (int i = 0; i < 5; i++) send(W'(16'h4000 + i), 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1 chk("s5_valid_in_reset", FW'(out_valid), FW'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) send(W'(16'h5000 + i), 1'b0);
    idle(3);
    chk("s5_nframes", FW'(got_q.size()), FW'(1));
    if (got_q.size() >= 1) begin
      chk("s5_slot0", FW'(slot(got_q[0].isum, 0)), FW'(16'h5000));
      chk("s5_slot7", FW'(slot(got_q[0].isum, 7)), FW'(16'h5007));
    end

    // Reset while in HOLD drops both pending frames
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(W'(16'h6000 + i), 1'b0);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    got_q.delete();
    idle(3);
    chk("s5b_dropped", FW'(got_q.size()), FW'(0));

    // Single word frame
    send(16'h1234, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    chk("s6_valid", FW'(out_valid), FW'(1));
    chk("s6_isum", out_isum, FW'(16'h1234));
    chk("s6_count", FW'(out_count), FW'(1));
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end
endmodule
